full_subtractor: RTL and testbench
==================================

Name: full_subtractor

Overview:
- Registered, parameterisable-width binary full subtractor with borrow-in and borrow-out.
- Computes d = a − b − b_in as a ripple-borrow chain of 1-bit full-subtractor cells.
- Captures the result, borrow and status flags in output registers one clock after a valid input.
- Used as an arithmetic leaf in datapaths. Cascade wide subtractors by feeding b_out into the next slice's b_in.

Parameters:
- WIDTH, 1, operand and difference width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  qualifies a, b, b_in on this clock edge
- a  input  WIDTH  minuend (unsigned, or two's complement for ovf)
- b  input  WIDTH  subtrahend
- b_in  input  1  borrow in (weight 1)
- d  output  WIDTH  registered difference
- b_out  output  1  registered borrow out of MSB
- out_valid  output  1  d/b_out/flags updated by previous accepted input
- zero  output  1  registered: d == 0
- ovf  output  1  registered signed overflow

Behaviour:
- Per-bit cell i: d_i = a_i ^ b_i ^ br_i; br_{i+1} = (~a_i & b_i) | (~a_i & br_i) | (b_i & br_i); br_0 = b_in; b_out = br_WIDTH.
- Arithmetic equivalent: {b_out, d} = {1'b0, a} − {1'b0, b} − b_in, taken modulo 2^(WIDTH+1).
- b_out = 1 iff a < b + b_in as unsigned values.
- ovf = (a[MSB] != b[MSB]) && (d_next[MSB] != a[MSB]), where d_next is the combinational difference.
- For WIDTH=1, ovf follows the same formula.
- Datapath is purely combinational from inputs to register D-pins. No internal state other than the output registers.
- Latency: exactly 1 cycle.
- On a rising clk edge with rst=0 and in_valid=1:
  - d, b_out, zero and ovf load the new results.
  - out_valid becomes 1.
- On a rising clk edge with rst=0 and in_valid=0:
  - d, b_out, zero and ovf hold their values.
  - out_valid becomes 0.
- On a rising clk edge with rst=1:
  - d=0, b_out=0, zero=0, ovf=0, out_valid=0.
  - Reset has priority over in_valid.
  - A transaction presented in the same cycle as reset is discarded.
- Reset is synchronous only. Asserting rst between edges has no effect until the next edge.
- Back-to-back valid inputs give one result per cycle. No stall and no backpressure.
- Wrap-around: results wrap modulo 2^WIDTH with b_out=1; no saturation.
- X on inputs with in_valid=0 must not corrupt the held outputs.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, a=3, b=1 → d=0, b_out=0, zero=0, ovf=0, out_valid=0. Deassert rst → first valid result appears 1 cycle later.
- WIDTH=1 exhaustive truth table, one vector per cycle, in_valid=1, check 1 cycle later. Inputs are (a,b,b_in); outputs are (d,b_out):
  - 000→(0,0); 001→(1,1); 010→(1,1); 011→(0,1)
  - 100→(1,0); 101→(0,0); 110→(0,0); 111→(1,1)
- WIDTH=8 borrow wrap: a=0x00, b=0x01, b_in=0 → d=0xFF, b_out=1, zero=0, ovf=0. Then a=0x05, b=0x04, b_in=1 → d=0x00, b_out=0, zero=1.
- WIDTH=8 signed overflow: a=0x80, b=0x01, b_in=0 → d=0x7F, b_out=0, ovf=1. Then a=0x7F, b=0xFF, b_in=0 → d=0x80, b_out=1, ovf=1.
- Hold/valid: after a result d=0x7F, drive in_valid=0 with random a/b for 3 cycles → d stays 0x7F, out_valid=0.
- Back-to-back and mid-stream reset: 20 random WIDTH=8 vectors on consecutive cycles, compared each cycle against the golden model (a − b − b_in). Assert rst on vector 10 → that cycle's outputs reset and vector 10 is discarded; vector 11 onward matches the model.

Source files
------------

// File: rtl/full_subtractor_if.sv
// Operand/result bundle for the registered full subtractor.
// The block is the slave. The master drives the operands and reads the registered results.
interface full_subtractor_if #(
  parameter int WIDTH = 1
);
  // valid-only handshake, with no ready and no backpressure:
  // - a, b and b_in are consumed on every rising edge where in_valid is high.
  // - out_valid is high for exactly one cycle per accepted input.
  // - d, b_out, zero and ovf hold their values when no new input is accepted.
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic [WIDTH-1:0] d;
  logic             b_out;
  logic             out_valid;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, b_in,
    input  d, b_out, out_valid, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, b_in,
    output d, b_out, out_valid, zero, ovf
  );
endinterface

// File: rtl/full_subtractor.sv
// Registered ripple-borrow full subtractor that computes d = a - b - b_in with one cycle of latency.
// Wide subtractors are cascaded by chaining b_out into the next slice's b_in.
module full_subtractor #(
  parameter int WIDTH = 1
) (
  input logic               clk,
  input logic               rst,
  full_subtractor_if.slave  bus
);

  logic [WIDTH-1:0] d_next;
  logic             b_out_next;
  logic             zero_next;
  logic             ovf_next;

  // A single running borrow variable models the chain of 1-bit cells without a self-referencing vector.
  always_comb begin
    logic br;
    br     = bus.b_in;
    d_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      d_next[i] = bus.a[i] ^ bus.b[i] ^ br;
      br        = (~bus.a[i] & bus.b[i]) | (~bus.a[i] & br) | (bus.b[i] & br);
    end
    b_out_next = br;
  end

  always_comb begin
    zero_next = (d_next == '0);
    ovf_next  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                (d_next[WIDTH-1] != bus.a[WIDTH-1]);
  end

  // Result registers load only on accepted inputs, so X on idle inputs cannot reach them.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.d         <= '0;
      bus.b_out     <= 1'b0;
      bus.zero      <= 1'b0;
      bus.ovf       <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.d     <= d_next;
        bus.b_out <= b_out_next;
        bus.zero  <= zero_next;
        bus.ovf   <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_full_subtractor.sv
// Directed bench for full_subtractor, using an 8-bit instance and a 1-bit instance.
// Observed tuples are {out_valid, b_out, zero, ovf, d}.
module tb_full_subtractor;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  full_subtractor_if #(.WIDTH(8)) bus8 ();
  full_subtractor_if #(.WIDTH(1)) bus1 ();

  full_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  full_subtractor #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  function automatic logic [11:0] obs8();
    return {bus8.out_valid, bus8.b_out, bus8.zero, bus8.ovf, bus8.d};
  endfunction

  function automatic logic [4:0] obs1();
    return {bus1.out_valid, bus1.b_out, bus1.zero, bus1.ovf, bus1.d};
  endfunction

  task automatic drive8(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic bi);
    bus8.in_valid = v;
    bus8.a        = av;
    bus8.b        = bv;
    bus8.b_in     = bi;
  endtask

  task automatic drive1(input logic v, input logic av, input logic bv, input logic bi);
    bus1.in_valid = v;
    bus1.a        = av;
    bus1.b        = bv;
    bus1.b_in     = bi;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive8(1'b1, 8'h03, 8'h01, 1'b0);
    drive1(1'b1, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (obs8() !== 12'h000) begin
        errors++;
        $display("FAIL reset8 cycle %0d: got %h expected %h", c, obs8(), 12'h000);
      end
      checks++;
      if (obs1() !== 5'h00) begin
        errors++;
        $display("FAIL reset1 cycle %0d: got %h expected %h", c, obs1(), 5'h00);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (obs8() !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h02}) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", obs8(), {1'b1, 3'b000, 8'h02});
    end
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_truth_table_w1();
    // Expected {d, b_out} for each (a, b, b_in) index.
    logic [1:0] exp_tt [8];
    exp_tt = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = i[2:0];
      drive1(1'b1, v[2], v[1], v[0]);
      tick();
      checks++;
      if ({bus1.out_valid, bus1.d, bus1.b_out} !== {1'b1, exp_tt[i]}) begin
        errors++;
        $display("FAIL truth_w1 abc=%b: got v,d,bo=%b expected %b", v,
                 {bus1.out_valid, bus1.d, bus1.b_out}, {1'b1, exp_tt[i]});
      end
    end
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_borrow_wrap();
    drive8(1'b1, 8'h00, 8'h01, 1'b0);
    tick();
    checks++;
    if (obs8() !== {1'b1, 1'b1, 1'b0, 1'b0, 8'hFF}) begin
      errors++;
      $display("FAIL wrap_00_01: got %h expected %h", obs8(), {4'b1100, 8'hFF});
    end
    drive8(1'b1, 8'h05, 8'h04, 1'b1);
    tick();
    checks++;
    if (obs8() !== {1'b1, 1'b0, 1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL zero_05_04_1: got %h expected %h", obs8(), {4'b1010, 8'h00});
    end
  endtask

  task automatic test_overflow();
    drive8(1'b1, 8'h80, 8'h01, 1'b0);
    tick();
    checks++;
    if (obs8() !== {1'b1, 1'b0, 1'b0, 1'b1, 8'h7F}) begin
      errors++;
      $display("FAIL ovf_80_01: got %h expected %h", obs8(), {4'b1001, 8'h7F});
    end
    drive8(1'b1, 8'h7F, 8'hFF, 1'b0);
    tick();
    checks++;
    if (obs8() !== {1'b1, 1'b1, 1'b0, 1'b1, 8'h80}) begin
      errors++;
      $display("FAIL ovf_7f_ff: got %h expected %h", obs8(), {4'b1101, 8'h80});
    end
  endtask

  task automatic test_hold();
    drive8(1'b1, 8'h80, 8'h01, 1'b0);
    tick();
    checks++;
    if (obs8() !== {1'b1, 1'b0, 1'b0, 1'b1, 8'h7F}) begin
      errors++;
      $display("FAIL hold_load: got %h expected %h", obs8(), {4'b1001, 8'h7F});
    end
    for (int c = 0; c < 3; c++) begin
      drive8(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      tick();
      checks++;
      if (obs8() !== {1'b0, 1'b0, 1'b0, 1'b1, 8'h7F}) begin
        errors++;
        $display("FAIL hold cycle %0d: got %h expected %h", c, obs8(), {4'b0001, 8'h7F});
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 20; k++) begin
      logic [7:0] av, bv, dv;
      logic       bi, bo, ov;
      av = 8'($urandom_range(0, 255));
      bv = 8'($urandom_range(0, 255));
      bi = 1'($urandom_range(0, 1));
      {bo, dv} = {1'b0, av} - {1'b0, bv} - {8'h00, bi};
      ov = (av[7] != bv[7]) && (dv[7] != av[7]);
      rst = (k == 10);
      drive8(1'b1, av, bv, bi);
      if (k == 10) exp_q.push_back(12'h000);
      else         exp_q.push_back({1'b1, bo, (dv == 8'h00), ov, dv});
      tick();
      checks++;
      begin
        logic [11:0] exp_v;
        exp_v = exp_q.pop_front();
        if (obs8() !== exp_v) begin
          errors++;
          $display("FAIL b2b vec %0d a=%h b=%h bi=%b: got %h expected %h", k, av, bv, bi, obs8(), exp_v);
        end
      end
    end
    rst = 1'b0;
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    checks++;
    if (bus8.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle out_valid: got %b expected 0", bus8.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_truth_table_w1();
    test_borrow_wrap();
    test_overflow();
    test_hold();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
